// File: rtl/z80_wb_pkg.sv
// Shared constants and FSM encoding for the Z80-to-Wishbone bridge.
package z80_wb_pkg;

  localparam logic [1:0] TAG_MEM   = 2'b00;
  localparam logic [1:0] TAG_IO    = 2'b01;
  localparam logic [1:0] TAG_INTA  = 2'b10;
  localparam logic [1:0] TAG_FETCH = 2'b11;

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

endpackage

// File: rtl/z80_wb_bridge.sv
// Registered bridge turning tv80s bus strobes into one Wishbone B4 classic
// cycle per CPU bus cycle, with wait-state stretching, tagging and timeout.
module z80_wb_bridge
  import z80_wb_pkg::*;
#(
  parameter int         ADDR_W   = 16,
  parameter int         MIN_WAIT = 0,
  parameter int         TIMEOUT  = 255,
  parameter logic [7:0] ERR_DATA = 8'hFF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_m1_n,
  input  logic              cpu_mreq_n,
  input  logic              cpu_iorq_n,
  input  logic              cpu_rd_n,
  input  logic              cpu_wr_n,
  input  logic              cpu_rfsh_n,
  input  logic [ADDR_W-1:0] cpu_adr_i,
  input  logic [7:0]        cpu_dat_i,
  output logic [7:0]        cpu_dat_o,
  output logic              cpu_wait_n_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [1:0]        wbm_tga_o,
  input  logic [7:0]        wbm_dat_i,
  output logic [7:0]        wbm_dat_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  input  logic              wbm_ack_i,
  input  logic              wbm_err_i,
  output logic              bus_err_o
);

  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam int WAIT_W = (CNT_W < 4) ? 4 : CNT_W;
  localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MIN_WAIT);

  state_t              state;
  logic [CNT_W-1:0]    to_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                req;
  logic                inta;
  logic                fetch;
  logic                wait_met;
  logic [1:0]          tag;

  assign inta     = ~cpu_m1_n & ~cpu_iorq_n;
  assign fetch    = ~cpu_m1_n & ~cpu_mreq_n;
  assign req      = cpu_rfsh_n &
                    (((~cpu_mreq_n | ~cpu_iorq_n) & (~cpu_rd_n | ~cpu_wr_n)) | inta);
  assign wait_met = (wait_cnt >= WAIT_MAX);

  // Outside DONE the CPU is held whenever it requests; in DONE only until
  // the minimum wait count has elapsed.
  assign cpu_wait_n_o = (state == DONE) ? wait_met : ~req;

  always_comb begin
    tag = TAG_MEM;
    if (inta)             tag = TAG_INTA;
    else if (fetch)       tag = TAG_FETCH;
    else if (~cpu_iorq_n) tag = TAG_IO;
  end

  // Handshake: a transfer completes on the first clock edge in BUS where
  // stb is high and the slave raises ack or err; err takes precedence and
  // both take precedence over an expiring timeout.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_tga_o <= TAG_MEM;
      cpu_dat_o <= '0;
      bus_err_o <= 1'b0;
      to_cnt    <= '0;
      wait_cnt  <= '0;
    end else begin
      bus_err_o <= 1'b0;
      if (state != IDLE && wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WAIT_W'(1);
      case (state)
        IDLE: begin
          if (req) begin
            wbm_adr_o <= cpu_adr_i;
            wbm_dat_o <= cpu_dat_i;
            wbm_we_o  <= ~cpu_wr_n;
            wbm_tga_o <= tag;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wait_cnt  <= '0;
            to_cnt    <= '0;
            state     <= BUS;
          end
        end
        BUS: begin
          if (wbm_err_i || (!wbm_ack_i && to_cnt == TO_LAST)) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            bus_err_o <= 1'b1;
            if (!wbm_we_o) cpu_dat_o <= ERR_DATA;
            state     <= DONE;
          end else if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            if (!wbm_we_o) cpu_dat_o <= wbm_dat_i;
            state     <= DONE;
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          // Requiring req to drop guarantees one Wishbone cycle per CPU cycle.
          if (wait_met && !req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_wb_bridge.sv
// Drives two bridges (MIN_WAIT 0 and 4) with identical CPU traffic and checks
// them against a transaction-level model of the bridge's observable behaviour.
module tb_z80_wb_bridge;

  localparam int TO = 8;
  localparam int K_MRD = 0, K_MWR = 1, K_IRD = 2, K_IWR = 3, K_FETCH = 4, K_INTA = 5, K_RFSH = 6;
  localparam int M_ACK = 0, M_ERR = 1, M_BOTH = 2, M_NONE = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
  logic [15:0] cpu_adr;
  logic [7:0]  cpu_wdat;
  logic [7:0]  sl_data;
  int          sl_mode;
  int          sl_lat;

  logic [7:0]  cpu_dat_o [2];
  logic        wait_n    [2];
  logic [15:0] wbm_adr   [2];
  logic [1:0]  wbm_tga   [2];
  logic [7:0]  wbm_dat_o [2];
  logic        cyc       [2];
  logic        stb       [2];
  logic        we        [2];
  logic        ack       [2];
  logic        err       [2];
  logic        bus_err   [2];
  int          stb_cnt   [2];
  int          mw        [2] = '{0, 4};

  for (genvar g = 0; g < 2; g++) begin : g_dut
    z80_wb_bridge #(.ADDR_W(16), .MIN_WAIT(g * 4), .TIMEOUT(TO), .ERR_DATA(8'hFF)) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .cpu_m1_n     (m1_n),
      .cpu_mreq_n   (mreq_n),
      .cpu_iorq_n   (iorq_n),
      .cpu_rd_n     (rd_n),
      .cpu_wr_n     (wr_n),
      .cpu_rfsh_n   (rfsh_n),
      .cpu_adr_i    (cpu_adr),
      .cpu_dat_i    (cpu_wdat),
      .cpu_dat_o    (cpu_dat_o[g]),
      .cpu_wait_n_o (wait_n[g]),
      .wbm_adr_o    (wbm_adr[g]),
      .wbm_tga_o    (wbm_tga[g]),
      .wbm_dat_i    (sl_data),
      .wbm_dat_o    (wbm_dat_o[g]),
      .wbm_cyc_o    (cyc[g]),
      .wbm_stb_o    (stb[g]),
      .wbm_we_o     (we[g]),
      .wbm_ack_i    (ack[g]),
      .wbm_err_i    (err[g]),
      .bus_err_o    (bus_err[g])
    );
  end

  // slave: responds in the sl_lat-th strobe cycle according to sl_mode
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      ack[g] = stb[g] && (sl_mode == M_ACK || sl_mode == M_BOTH) && (stb_cnt[g] == sl_lat - 1);
      err[g] = stb[g] && (sl_mode == M_ERR || sl_mode == M_BOTH) && (stb_cnt[g] == sl_lat - 1);
    end
  end

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++)
      stb_cnt[g] <= (stb[g] && !ack[g] && !err[g]) ? stb_cnt[g] + 1 : 0;
  end

  // monitor
  logic        mon_en = 1'b0;
  logic        stb_q    [2] = '{1'b0, 1'b0};
  int          starts   [2];
  int          stb_cyc  [2];
  int          wait_lo  [2];
  int          err_p    [2];
  logic        unstable [2];
  logic [15:0] cap_adr  [2];
  logic [1:0]  cap_tga  [2];
  logic [7:0]  cap_dat  [2];
  logic        cap_we   [2];

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (mon_en) begin
        if (stb[g] && !stb_q[g]) begin
          starts[g]++;
          cap_adr[g] = wbm_adr[g];
          cap_tga[g] = wbm_tga[g];
          cap_dat[g] = wbm_dat_o[g];
          cap_we[g]  = we[g];
        end else if (stb[g] && (cap_adr[g] != wbm_adr[g] || cap_tga[g] != wbm_tga[g] ||
                                cap_dat[g] != wbm_dat_o[g] || cap_we[g] != we[g])) begin
          unstable[g] = 1'b1;
        end
        if (stb[g])     stb_cyc[g]++;
        if (!wait_n[g]) wait_lo[g]++;
        if (bus_err[g]) err_p[g]++;
      end
      stb_q[g] = stb[g];
    end
  end

  // scoreboard
  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] last_rd [2] = '{8'h00, 8'h00};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_strobes(input int kind);
    m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
    case (kind)
      K_MRD:   begin mreq_n = 1'b0; rd_n = 1'b0; end
      K_MWR:   begin mreq_n = 1'b0; wr_n = 1'b0; end
      K_IRD:   begin iorq_n = 1'b0; rd_n = 1'b0; end
      K_IWR:   begin iorq_n = 1'b0; wr_n = 1'b0; end
      K_FETCH: begin m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0; end
      K_INTA:  begin m1_n = 1'b0; iorq_n = 1'b0; end
      K_RFSH:  begin rfsh_n = 1'b0; mreq_n = 1'b0; end
      default: ;
    endcase
  endtask

  // driver: one CPU bus cycle, held until both bridges release wait and at least `hold` cycles
  task automatic run_txn(input int kind, input logic [15:0] a, input logic [7:0] d,
                         input logic [7:0] rdat, input int mode, input int lat, input int hold);
    logic       issued, is_wr, is_rd, fails;
    logic [1:0] exp_tag;
    int         n, exp_cyc, exp_wait;
    bit         done;
    @(posedge clk); #1;
    for (int g = 0; g < 2; g++) begin
      starts[g] = 0; stb_cyc[g] = 0; wait_lo[g] = 0; err_p[g] = 0; unstable[g] = 1'b0;
    end
    sl_mode = mode; sl_lat = lat; sl_data = rdat;
    cpu_adr = a; cpu_wdat = d;
    mon_en = 1'b1;
    set_strobes(kind);
    n = 0; done = 0;
    while (!done) begin
      @(negedge clk); n++;
      if (wait_n[0] && wait_n[1] && n >= hold) done = 1;
      else if (n > 200) begin chk("wait_release", 32'(n), 32'd0); done = 1; end
    end
    @(posedge clk); #1;
    set_strobes(-1);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;

    // reference model
    issued  = (kind != K_RFSH);
    is_wr   = (kind == K_MWR || kind == K_IWR);
    is_rd   = issued && !is_wr;
    fails   = (mode != M_ACK) || (lat > TO);
    exp_cyc = !issued ? 0 : (mode == M_NONE) ? TO : lat;
    case (kind)
      K_IRD, K_IWR: exp_tag = 2'b01;
      K_FETCH:      exp_tag = 2'b11;
      K_INTA:       exp_tag = 2'b10;
      default:      exp_tag = 2'b00;
    endcase
    for (int g = 0; g < 2; g++) begin
      exp_wait = !issued ? 0 : ((exp_cyc > mw[g]) ? exp_cyc : mw[g]) + 1;
      if (is_rd) last_rd[g] = fails ? 8'hFF : rdat;
      chk($sformatf("stb_starts%0d", g), 32'(starts[g]), 32'(issued));
      chk($sformatf("stb_cycles%0d", g), 32'(stb_cyc[g]), 32'(exp_cyc));
      chk($sformatf("wait_lo%0d", g), 32'(wait_lo[g]), 32'(exp_wait));
      chk($sformatf("bus_err%0d", g), 32'(err_p[g]), 32'(issued && fails));
      chk($sformatf("cpu_dat%0d", g), 32'(cpu_dat_o[g]), 32'(last_rd[g]));
      chk($sformatf("cyc_idle%0d", g), 32'(cyc[g]), 32'd0);
      if (issued) begin
        chk($sformatf("tga%0d", g), 32'(cap_tga[g]), 32'(exp_tag));
        chk($sformatf("adr%0d", g), 32'(cap_adr[g]), 32'(a));
        chk($sformatf("we%0d", g), 32'(cap_we[g]), 32'(is_wr));
        chk($sformatf("stable%0d", g), 32'(unstable[g]), 32'd0);
        if (is_wr) chk($sformatf("wdat%0d", g), 32'(cap_dat[g]), 32'(d));
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s_cyc%0d", tag, g), 32'(cyc[g]), 32'd0);
      chk($sformatf("%s_stb%0d", tag, g), 32'(stb[g]), 32'd0);
      chk($sformatf("%s_we%0d", tag, g), 32'(we[g]), 32'd0);
      chk($sformatf("%s_adr%0d", tag, g), 32'(wbm_adr[g]), 32'd0);
      chk($sformatf("%s_tga%0d", tag, g), 32'(wbm_tga[g]), 32'd0);
      chk($sformatf("%s_wdat%0d", tag, g), 32'(wbm_dat_o[g]), 32'd0);
      chk($sformatf("%s_cpudat%0d", tag, g), 32'(cpu_dat_o[g]), 32'd0);
      chk($sformatf("%s_berr%0d", tag, g), 32'(bus_err[g]), 32'd0);
      chk($sformatf("%s_wait%0d", tag, g), 32'(wait_n[g]), 32'd1);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    set_strobes(-1);
    cpu_adr = '0; cpu_wdat = '0; sl_data = '0; sl_mode = M_ACK; sl_lat = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("rst");
    rst_i = 1'b0;

    run_txn(K_MRD,   16'h1234, 8'h00, 8'hA5, M_ACK,  1,  0);
    run_txn(K_IWR,   16'h00FE, 8'h3C, 8'h11, M_ACK,  3,  0);
    run_txn(K_FETCH, 16'h0100, 8'h00, 8'h3E, M_ACK,  2,  0);
    run_txn(K_INTA,  16'h0038, 8'h00, 8'hFF, M_ACK,  1,  0);
    run_txn(K_RFSH,  16'h007F, 8'h00, 8'h77, M_ACK,  1,  3);
    run_txn(K_MRD,   16'h4000, 8'h00, 8'h5A, M_NONE, 1,  0);
    run_txn(K_MRD,   16'h2000, 8'h00, 8'hC3, M_ACK,  1, 10);
    run_txn(K_MRD,   16'h2001, 8'h00, 8'h81, M_ACK, TO,  0);
    run_txn(K_IRD,   16'h0010, 8'h00, 8'h42, M_BOTH, 2,  0);
    run_txn(K_MWR,   16'h8000, 8'h99, 8'h24, M_ERR,  1,  0);

    // reset in the middle of a stalled bus cycle, then a clean cycle
    @(posedge clk); #1;
    sl_mode = M_NONE; cpu_adr = 16'hBEEF; cpu_wdat = 8'h55;
    set_strobes(K_MWR);
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b1;
    set_strobes(-1);
    @(posedge clk);
    @(negedge clk);
    check_reset_state("midrst");
    rst_i = 1'b0;
    last_rd[0] = 8'h00; last_rd[1] = 8'h00;
    run_txn(K_MRD, 16'h1111, 8'h00, 8'h6B, M_ACK, 2, 0);

    for (int i = 0; i < 40; i++) begin
      int kind, r, mode;
      kind = $urandom_range(0, 6);
      r    = $urandom_range(0, 9);
      mode = (r == 0) ? M_NONE : (r == 1) ? M_ERR : (r == 2) ? M_BOTH : M_ACK;
      run_txn(kind, 16'($urandom), 8'($urandom), 8'($urandom), mode,
              $urandom_range(1, TO), $urandom_range(0, 12));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
